// File: rtl/regdump_pkg.sv
// regdump_pkg: shared state encoding and default widths for the register-file dump reader
package regdump_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, DONE} state_t;
endpackage

// File: rtl/regdump_csum.sv
// regdump_csum: running XOR accumulator with synchronous clear and enable
// Ports: clk, rst (sync, active-high), clr (zero the sum), en (fold d in), d (input word), q (running XOR)
module regdump_csum #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    always_ff @(posedge clk)
        if (rst || clr) q <= '0;
        else if (en)    q <= q ^ d;
endmodule

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks registers FIRST_REG..LAST_REG via an async read port and streams (addr, data) beats
// Ports: clk, rst (sync, active-high), start (dump request, honoured in IDLE only), busy, done (1-cycle pulse),
//        rs_dump/data_dump (regfile read port), out_valid/out_ready/out_addr/out_data (beat stream)
// Option: REGDUMP_CHECKSUM_EN appends a final beat at out_addr='1 carrying the XOR of all dumped values
module regfile_dump_reader
    import regdump_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rs_dump,
    input  logic [DATA_W-1:0] data_dump,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);
    if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG >= 2**ADDR_W) begin : g_bad_range
        $error("regfile_dump_reader: register range out of bounds");
    end

    state_t            state, state_nx;
    logic [ADDR_W-1:0] idx;
    logic              hs, last;

    assign hs      = out_valid && out_ready;
    // Ending on equality rather than overflow lets LAST_REG be the top index
    assign last    = idx == ADDR_W'(LAST_REG);
    assign rs_dump = idx;
    assign done    = state == DONE;

`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
    regdump_csum #(.DATA_W(DATA_W)) u_csum (
        .clk (clk),
        .rst (rst),
        .clr (state == IDLE && start),
        .en  (state == READ),
        .d   (data_dump),
        .q   (csum)
    );
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = start ? READ : IDLE;
            READ: state_nx = SEND;
`ifdef REGDUMP_CHECKSUM_EN
            SEND: state_nx = hs ? (last ? CSUM : READ) : SEND;
            CSUM: state_nx = hs ? DONE : CSUM;
`else
            SEND: state_nx = hs ? (last ? DONE : READ) : SEND;
`endif
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    idx  <= ADDR_W'(FIRST_REG);
                    busy <= 1'b1;
                end
                READ: begin
                    out_data  <= data_dump;
                    out_addr  <= idx;
                    out_valid <= 1'b1;
                end
                SEND: if (hs) begin
                    out_valid <= 1'b0;
                    if (!last) idx <= idx + ADDR_W'(1);
`ifdef REGDUMP_CHECKSUM_EN
                    // The accumulator already holds the last register, so the checksum beat follows immediately
                    else begin
                        out_valid <= 1'b1;
                        out_addr  <= '1;
                        out_data  <= csum;
                    end
`endif
                end
                CSUM: if (hs) out_valid <= 1'b0;
                DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: directed bench for regfile_dump_reader (full walk, partial walk, backpressure, ignored start, reset abort)
module tb_regfile_dump_reader;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, start_a, start_b, ready, sel;
    logic        busy_a, done_a, valid_a, busy_b, done_b, valid_b;
    logic [4:0]  rs_a, addr_a, rs_b, addr_b;
    logic [31:0] dd_a, data_a, dd_b, data_b;
    logic        m_busy, m_done, m_valid;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rf(input int a);
        case (a)
            1:       return 32'h12345678;
            2:       return 32'h87654321;
            5:       return 32'hDEADBEEF;
            default: return 32'h0;
        endcase
    endfunction

    assign dd_a = rf(int'(rs_a));
    assign dd_b = rf(int'(rs_b));

    regfile_dump_reader dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .rs_dump(rs_a), .data_dump(dd_a), .out_valid(valid_a), .out_ready(ready),
        .out_addr(addr_a), .out_data(data_a)
    );

    regfile_dump_reader #(.FIRST_REG(1), .LAST_REG(5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .rs_dump(rs_b), .data_dump(dd_b), .out_valid(valid_b), .out_ready(ready),
        .out_addr(addr_b), .out_data(data_b)
    );

    always_comb begin
        m_busy  = sel ? busy_b  : busy_a;
        m_done  = sel ? done_b  : done_a;
        m_valid = sel ? valid_b : valid_a;
        m_addr  = sel ? addr_b  : addr_a;
        m_data  = sel ? data_b  : data_a;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    task automatic run_dump(input int first, input int last, input int stall_addr,
                            input int stall_n, input bit timing, input bit restart);
        int exp_a = first, beats = 0, dones = 0, extra = 0, stall_left = stall_n, cyc = 0;
        logic [31:0] acc = 32'h0;
        bit fin = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        check("busy_on", {31'h0, m_busy}, 32'h1);
        check("valid_before_read", {31'h0, m_valid}, 32'h0);
        while (!fin && cyc < 400) begin
            if (restart) set_start(beats == 2 || m_done);
            if (m_done) begin
                dones++;
                fin = 1'b1;
                check("busy_in_done", {31'h0, m_busy}, 32'h1);
            end else if (m_valid) begin
                if (stall_left > 0 && int'(m_addr) == stall_addr) begin
                    ready = 1'b0;
                    stall_left--;
                    check("stall_addr", {27'h0, m_addr}, stall_addr);
                    check("stall_data", m_data, rf(stall_addr));
                end else begin
                    ready = 1'b1;
                    if (exp_a <= last) begin
                        check("beat_addr", {27'h0, m_addr}, exp_a);
                        check("beat_data", m_data, rf(exp_a));
                        if (timing) check("beat_cycle", cyc, 1 + 2 * (exp_a - first));
                        acc ^= rf(exp_a);
                    end else begin
                        check("csum_addr", {27'h0, m_addr}, 32'h1F);
                        check("csum_data", m_data, acc);
                    end
                    exp_a++;
                    beats++;
                end
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin) check("done_timeout", 32'h0, 32'h1);
        set_start(1'b0);
        ready = 1'b1;
        check("beat_count", beats, last - first + 1 + CS);
        repeat (6) begin
            @(negedge clk);
            if (m_done)  dones++;
            if (m_valid) extra++;
        end
        check("done_count", dones, 1);
        check("no_extra_beats", extra, 0);
        check("busy_off", {31'h0, m_busy}, 32'h0);
    endtask

    initial begin
        int n;
        int bad_done;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready = 1'b1; sel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'h0, valid_a}, 32'h0);
        check("rst_busy", {31'h0, busy_a}, 32'h0);
        check("rst_done", {31'h0, done_a}, 32'h0);
        check("rst_addr", {27'h0, addr_a}, 32'h0);
        check("rst_data", data_a, 32'h0);
        check("rst_rs", {27'h0, rs_a}, 32'h0);
        check("rst_valid_b", {31'h0, valid_b}, 32'h0);
        rst = 1'b0;

        run_dump(0, 31, -1, 0, 1'b1, 1'b0);
        run_dump(0, 31, 2, 5, 1'b0, 1'b0);
        sel = 1'b1;
        run_dump(1, 5, -1, 0, 1'b1, 1'b0);
        sel = 1'b0;
        run_dump(0, 31, -1, 0, 1'b0, 1'b1);

        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (!(valid_a && addr_a == 5'd3) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_beat3", {31'h0, valid_a && addr_a == 5'd3}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", {31'h0, valid_a}, 32'h0);
        check("abort_busy", {31'h0, busy_a}, 32'h0);
        check("abort_addr", {27'h0, addr_a}, 32'h0);
        check("abort_data", data_a, 32'h0);
        bad_done = int'(done_a);
        repeat (5) begin
            @(negedge clk);
            bad_done += int'(done_a) + int'(valid_a);
        end
        check("abort_quiet", bad_done, 0);
        run_dump(0, 31, -1, 0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
